mc_ctrl_fsm: RTL

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects, ALU op and write strobes per state, with a ready/request handshake to a shared instruction/data memory.
- Sits between the instruction register, the ALU zero flag and the multi-cycle datapath.

---
 rtl/mc_ctrl_fsm_if.sv | 22 ++
 rtl/mc_ctrl_fsm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Memory handshake bundle between the multi-cycle controller and the shared
// instruction/data memory port.
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_rdy;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_rdy
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_rdy
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing with memory handshake.
// Optional illegal-instruction trap enabled by defining MC_CTRL_ILLEGAL_TRAP_EN.
module mc_ctrl_fsm #(
  parameter int ALU_W       = 5,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_ctrl_fsm_if.master    mem,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem2reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext,
  output logic [ALU_W-1:0] alu_op,
  output logic [2:0]       state,
  output logic             retire,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic             mem_err
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(9);
  localparam logic [ALU_W-1:0] ALU_NOR  = ALU_W'(10);

  localparam bit            TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TO_W:0] TO_LIMIT = MEM_TIMEOUT[TO_W:0];

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic [TO_W:0]   wait_inc;
  logic [5:0]      op_q, op_d, funct_q, funct_d;
  logic            mem_err_q, mem_err_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic            illegal_q, illegal_d;
`endif

  logic [5:0]       dec_op, dec_funct;
  logic             r_ok, r_shift, i_ok, i_ext;
  logic [ALU_W-1:0] r_alu, i_alu;
  logic [1:0]       i_src_a, i_src_b;
  logic             stall;
  logic             mem_req_c, mem_we_c, iord_c;

  // ID decodes the live IR fields since the latch only holds them from EX on.
  assign dec_op    = (state_q == ST_ID) ? op    : op_q;
  assign dec_funct = (state_q == ST_ID) ? funct : funct_q;

  always_comb begin
    r_ok    = 1'b1;
    r_shift = 1'b0;
    r_alu   = ALU_ADD;
    case (dec_funct)
      6'h00:        begin r_alu = ALU_SLL; r_shift = 1'b1; end
      6'h02:        begin r_alu = ALU_SRL; r_shift = 1'b1; end
      6'h03:        begin r_alu = ALU_SRA; r_shift = 1'b1; end
      6'h20, 6'h21: r_alu = ALU_ADD;
      6'h22, 6'h23: r_alu = ALU_SUB;
      6'h24:        r_alu = ALU_AND;
      6'h25:        r_alu = ALU_OR;
      6'h26:        r_alu = ALU_XOR;
      6'h27:        r_alu = ALU_NOR;
      6'h2A:        r_alu = ALU_SLT;
      6'h2B:        r_alu = ALU_SLTU;
      default:      r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_ok    = 1'b1;
    i_alu   = ALU_ADD;
    i_ext   = 1'b0;
    i_src_a = 2'b00;
    i_src_b = 2'b10;
    case (dec_op)
      OP_R: begin
        i_ok    = r_ok;
        i_alu   = r_alu;
        i_src_b = r_shift ? 2'b01 : 2'b00;
      end
      OP_ADDIU, OP_LW, OP_SW: i_alu = ALU_ADD;
      OP_SLTI:  begin i_alu = ALU_SLT; i_ext = 1'b1; end
      OP_SLTIU: i_alu = ALU_SLTU;
      OP_ANDI:  i_alu = ALU_AND;
      OP_ORI:   i_alu = ALU_OR;
      OP_XORI:  i_alu = ALU_XOR;
      OP_LUI:   begin i_alu = ALU_SLL; i_src_a = 2'b01; end
      OP_BEQ, OP_BNE: begin
        i_alu   = ALU_SUB;
        i_src_b = 2'b00;
        i_ext   = 1'b1;
      end
      OP_J:     i_src_b = 2'b00;
      default:  i_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    mem_err_d = mem_err_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    wait_d    = wait_q;
    wait_inc  = {1'b0, wait_q} + 1'b1;
    stall     = 1'b0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    iord_c    = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 2'b00;
    reg_wr    = 1'b0;
    reg_dst   = 2'b00;
    mem2reg   = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    ext       = 1'b0;
    alu_op    = ALU_ADD;
    retire    = 1'b0;

    case (state_q)
      ST_IF: begin
        mem_req_c = 1'b1;
        if (mem.mem_rdy) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = ST_ID;
        end else begin
          stall = 1'b1;
        end
      end
      ST_ID: begin
        op_d    = op;
        funct_d = funct;
        if (op == OP_J) begin
          pc_wr   = 1'b1;
          pc_src  = 2'b10;
          retire  = 1'b1;
          state_d = ST_IF;
        end else if (i_ok) begin
          state_d = ST_EX;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = ST_HALT;
`else
          retire  = 1'b1;
          state_d = ST_IF;
`endif
        end
      end
      ST_EX: begin
        alu_op    = i_alu;
        alu_src_a = i_src_a;
        alu_src_b = i_src_b;
        ext       = i_ext;
        case (op_q)
          OP_BEQ, OP_BNE: begin
            pc_wr   = (op_q == OP_BEQ) ? zero : ~zero;
            pc_src  = 2'b01;
            retire  = 1'b1;
            state_d = ST_IF;
          end
          OP_LW, OP_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = (op_q == OP_SW);
        if (mem.mem_rdy) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          stall = 1'b1;
        end
      end
      ST_WB: begin
        reg_wr  = 1'b1;
        retire  = 1'b1;
        reg_dst = {1'b0, op_q == OP_R};
        mem2reg = {1'b0, op_q == OP_LW};
        state_d = ST_IF;
      end
      default: state_d = ST_HALT;
    endcase

    // Counter saturates so the unlimited-timeout build never wraps.
    if (stall) begin
      if (wait_q != {TO_W{1'b1}}) wait_d = wait_inc[TO_W-1:0];
      if (TO_EN && (wait_inc == TO_LIMIT)) begin
        mem_err_d = 1'b1;
        state_d   = ST_HALT;
      end
    end
    if ((state_d != state_q) && ((state_d == ST_IF) || (state_d == ST_MEM)))
      wait_d = '0;

    if (!rst_n) begin
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      ir_wr     = 1'b0;
      pc_wr     = 1'b0;
      reg_wr    = 1'b0;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IF;
      wait_q    <= '0;
      op_q      <= '0;
      funct_q   <= '0;
      mem_err_q <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      mem_err_q <= mem_err_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign mem.iord    = iord_c;
  assign state       = state_q;
  assign mem_err     = mem_err_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal     = illegal_q;
`endif

endmodule
